// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback path.
package rf_pkg;

    localparam int unsigned RF_AW    = 5;
    localparam int unsigned RF_DW    = 32;
    localparam int unsigned RF_NREGS = 32;
    localparam logic [RF_AW-1:0] RF_ZERO = 5'd0;

    typedef struct packed {
        logic [RF_AW-1:0] adr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Dual-push, single-pop FIFO of register-file writes; push0 is the older of the two pushes.
// With RF_WB_BYPASS_EN defined, the storage and read pointer are exposed for the forwarding search.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push0,
    input  rf_wr_t                   i_wr0,
    input  logic                     i_push1,
    input  rf_wr_t                   i_wr1,
    input  logic                     i_pop,
    output rf_wr_t                   o_head,
    output logic [$clog2(DEPTH):0]   o_count
`ifdef RF_WB_BYPASS_EN
    ,
    output rf_wr_t                   o_entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0] o_rptr
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);

    rf_wr_t        r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic [PW-1:0] w_wptr1;

    // A lone push1 lands at the write pointer so entries stay contiguous.
    assign w_wptr1 = r_wptr + PW'(i_push0);
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

`ifdef RF_WB_BYPASS_EN
    assign o_entries = r_mem;
    assign o_rptr    = r_rptr;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push0) r_mem[r_wptr] <= i_wr0;
            if (i_push1) r_mem[w_wptr1] <= i_wr1;
            r_wptr <= r_wptr + PW'(i_push0) + PW'(i_push1);
            if (i_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + (PW+1)'(i_push0) + (PW+1)'(i_push1) - (PW+1)'(i_pop);
        end
    end

endmodule

// File: rtl/rf_write_sequencer.sv
// Register-file write front end: accepts MEM/ALU writebacks, drops r0, drains one write per cycle.
// Optional forwarding lookup ports are enabled by defining RF_WB_BYPASS_EN.
module rf_write_sequencer
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = RF_AW,
    parameter int unsigned DW    = RF_DW
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   AluValid,
    output logic                   AluReady,
    input  logic [AW-1:0]          AluAdr,
    input  logic [DW-1:0]          AluData,
    input  logic                   MemValid,
    output logic                   MemReady,
    input  logic [AW-1:0]          MemAdr,
    input  logic [DW-1:0]          MemData,
    output logic [AW-1:0]          Awr,
    output logic [DW-1:0]          Din,
    output logic                   WrEn,
    output logic [$clog2(DEPTH):0] Count
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [AW-1:0]          LkAdr1,
    input  logic [AW-1:0]          LkAdr2,
    output logic                   Byp1Hit,
    output logic                   Byp2Hit,
    output logic [DW-1:0]          Byp1Data,
    output logic [DW-1:0]          Byp2Data
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_free;
    logic          w_mem_push;
    logic          w_alu_push;
    logic          w_pop;
    rf_wr_t        w_wr_mem;
    rf_wr_t        w_wr_alu;
    rf_wr_t        w_head;
    logic [AW-1:0] r_awr;
    logic [DW-1:0] r_din;
    logic          r_wren;

    // Credit comes only from the registered count; a same-cycle pop is not counted.
    assign w_free     = CW'(DEPTH) - w_count;
    assign MemReady   = Rst_n && (w_free >= CW'(1));
    assign w_mem_push = MemValid && MemReady && (MemAdr != RF_ZERO);
    assign AluReady   = Rst_n && ((w_free >= CW'(2)) || ((w_free >= CW'(1)) && !w_mem_push));
    assign w_alu_push = AluValid && AluReady && (AluAdr != RF_ZERO);
    assign w_pop      = (w_count != '0);

    assign w_wr_mem = '{adr: MemAdr, data: MemData};
    assign w_wr_alu = '{adr: AluAdr, data: AluData};

`ifdef RF_WB_BYPASS_EN
    localparam int unsigned PW = $clog2(DEPTH);

    rf_wr_t        w_entries [DEPTH];
    logic [PW-1:0] w_rptr;
`endif

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (Clk),
        .i_rst_n   (Rst_n),
        .i_push0   (w_mem_push),
        .i_wr0     (w_wr_mem),
        .i_push1   (w_alu_push),
        .i_wr1     (w_wr_alu),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count)
`ifdef RF_WB_BYPASS_EN
        ,
        .o_entries (w_entries),
        .o_rptr    (w_rptr)
`endif
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_awr  <= '0;
            r_din  <= '0;
            r_wren <= 1'b0;
        end else if (w_pop) begin
            r_awr  <= w_head.adr;
            r_din  <= w_head.data;
            r_wren <= 1'b1;
        end else begin
            r_wren <= 1'b0;
        end
    end

    assign Awr   = r_awr;
    assign Din   = r_din;
    assign WrEn  = r_wren;
    assign Count = w_count;

`ifdef RF_WB_BYPASS_EN
    typedef struct packed {
        logic          hit;
        logic [DW-1:0] data;
    } byp_t;

    // Scan oldest to newest (output register first) so the newest match overwrites.
    function automatic byp_t lookup(input logic [AW-1:0] a);
        byp_t          res;
        logic [PW-1:0] idx;
        res = '0;
        if (a != RF_ZERO) begin
            if (r_wren && (r_awr == a)) begin
                res.hit  = 1'b1;
                res.data = r_din;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = w_rptr + PW'(i);
                if ((CW'(i) < w_count) && (w_entries[idx].adr == a)) begin
                    res.hit  = 1'b1;
                    res.data = w_entries[idx].data;
                end
            end
        end
        return res;
    endfunction

    assign {Byp1Hit, Byp1Data} = lookup(LkAdr1);
    assign {Byp2Hit, Byp2Data} = lookup(LkAdr2);
`endif

endmodule
